alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle execute controller between the control unit's ALU decoder and the combinational ALU. It accepts one operation at a time with its `alucontrol` code and operands. Single-cycle operations go through the external ALU and the result is registered. Multiply (`4'b0010`) and divide (`4'b0011`) run iteratively inside the block. A `busy` output lets the control unit stall the pipeline until `done`.

## Interface
Parameters:
- `WIDTH`, 16: operand and result width; must be ≥ 2.

Ports (clock and reset first):
- `clk`  in  1  system clock, all state updates on the rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  request valid; accepted only when `in_ready`=1
- `alucontrol`  in  4  operation code, latched on accept
- `a`  in  WIDTH  operand A, latched on accept
- `b`  in  WIDTH  operand B, latched on accept
- `alu_y`  in  WIDTH  result from the external combinational ALU
- `alu_ctl`  out  4  latched op code driven to the external ALU
- `alu_a`  out  WIDTH  latched A driven to the external ALU
- `alu_b`  out  WIDTH  latched B driven to the external ALU
- `in_ready`  out  1  1 only in IDLE
- `busy`  out  1  1 in ALU, MUL, DIV and DONE (equals `!in_ready`)
- `done`  out  1  1-cycle pulse; `result`, `hi` and `dz` are valid during it
- `result`  out  WIDTH  simple op: `alu_y`; MUL: low product; DIV: quotient
- `hi`  out  WIDTH  MUL: high product; DIV: remainder; simple op: 0
- `dz`  out  1  divide-by-zero flag; valid with `done`

## Operation
- States: IDLE, ALU, MUL, DIV, DONE.
- Accept: `start` && IDLE at an edge latches `alucontrol`, `a` and `b`, then moves to:
  - MUL for `4'b0010`
  - DIV for `4'b0011`
  - ALU for every other code, including `4'b1010` (jr) and unused `4'b1111`
- `start` outside IDLE is ignored; no queueing.
- ALU (one cycle): `alu_ctl`/`alu_a`/`alu_b` show the latched values. At the edge, `result`←`alu_y` and `hi`←0; go to DONE.
- MUL, unsigned shift-add over a 2·WIDTH accumulator {P_hi, P_lo}:
  - Init: P_lo=b, P_hi=0, count=WIDTH.
  - Each cycle: if P_lo[0], P_hi+=a with the carry kept in a WIDTH+1 sum; then shift {carry, P_hi, P_lo} right by 1; count−1.
  - At count=1 the final step's outputs go to `result`=P_lo and `hi`=P_hi; go to DONE.
- DIV, unsigned restoring division:
  - Init: R=0, Q=a, count=WIDTH.
  - Each cycle: {R,Q}<<=1; if R≥b then R−=b and Q[0]=1.
  - After WIDTH iterations: `result`=Q, `hi`=R.
  - b=0 skips the iteration: one DIV cycle sets `result`=all ones, `hi`=a, `dz`=1.
- DONE (one cycle): `done`=1, then IDLE. `dz` is 0 for every non-DIV op and for b≠0.
- `result`, `hi` and `dz` hold their values until the next completion overwrites them.
- `alu_ctl`, `alu_a` and `alu_b` always reflect the latched registers.

## Timing
- Reset values: state IDLE, `in_ready`=1, `busy`=0, `done`=0, `dz`=0, `result`=0, `hi`=0, `alu_ctl`=0, `alu_a`=0, `alu_b`=0, count=0.
- `reset` mid-operation aborts at the next edge. No `done` is produced and outputs return to reset values. `reset` wins over a simultaneous `start`.
- Latency, counted from the accept edge (cycle 0) to the first cycle `done`=1:
  - simple op: 2
  - MUL: WIDTH+1
  - DIV, b≠0: WIDTH+1
  - DIV, b=0: 2
- Throughput: the next accept can happen at the edge ending the cycle after DONE (IDLE cycle). Back-to-back simple ops therefore accept every 3 cycles.
- The external ALU is combinational. `alu_y` is sampled only at the edge ending the ALU state.
- Arithmetic is unsigned modulo 2^WIDTH per half. The multiply carry must not be lost: MUL 0xFFFF×0xFFFF is exact.

## Test plan
- Reset, then `start` with add (`0000`), a=3, b=4, bench ALU model returns 7 → `done` at cycle 2 with `result`=0x0007, `hi`=0, `dz`=0.
- MUL a=300, b=500 → `done` at cycle 17 with `hi`=0x0002, `result`=0x49F0. Also MUL 0xFFFF×0xFFFF → `hi`=0xFFFE, `result`=0x0001.
- DIV a=1000, b=7 → `done` at cycle 17 with `result`=0x008E, `hi`=0x0006, `dz`=0. Also DIV 5/0 → `done` at cycle 2 with `result`=0xFFFF, `hi`=0x0005, `dz`=1.
- `start` held high throughout a MUL → the second op is accepted only in the IDLE cycle after `done`. `busy` is high for exactly 17 cycles per MUL.
- `reset` at cycle 8 of a MUL → the next cycle shows `busy`=0, `result`=0, and no `done` pulse. A following add completes normally.
- Random sweep of 1000 ops mixing all 16 codes → a scoreboard matches `result`, `hi`, `dz` and latency against the reference arithmetic.

Source files
------------

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer_if
//  Description : Request/result bundle between the control unit, the
//                multi-cycle execute controller and the external ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       alucontrol;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] alu_y;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             dz;

  // Control unit plus external ALU side
  modport master (
    output start, alucontrol, a, b, alu_y,
    input  alu_ctl, alu_a, alu_b, in_ready, busy, done, result, hi, dz
  );

  // Sequencer side
  modport slave (
    input  start, alucontrol, a, b, alu_y,
    output alu_ctl, alu_a, alu_b, in_ready, busy, done, result, hi, dz
  );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Multi-cycle execute controller. Simple ops are routed through
//                the external combinational ALU; multiply (shift-add) and
//                divide (restoring) iterate internally over WIDTH cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  alu_sequencer_if.slave bus
);

  localparam int         c_CW  = $clog2(WIDTH + 1);
  localparam logic [3:0] c_MUL = 4'b0010;
  localparam logic [3:0] c_DIV = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ALU  = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_ctl;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [c_CW-1:0]  r_cnt;
  // Shared accumulator: MUL uses {P_hi, P_lo}, DIV uses {R, Q}
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi;
  logic             r_dz;

  logic             w_last;
  logic             w_b_zero;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH:0]   w_div_sh;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;

  assign w_last   = (r_cnt == c_CW'(1));
  assign w_b_zero = (r_b == '0);

  // Multiply step: the add keeps its carry so the shift brings it into P_hi
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_a} : '0);
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};

  // Divide step: shifted remainder needs one extra bit before the compare;
  // after subtracting it always fits back into WIDTH bits
  assign w_div_sh  = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_ge  = (w_div_sh >= {1'b0, r_b});
  assign w_div_rem = w_div_ge ? (w_div_sh[WIDTH-1:0] - r_b) : w_div_sh[WIDTH-1:0];
  assign w_div_quo = {r_acc_lo[WIDTH-2:0], w_div_ge};

  assign bus.alu_ctl  = r_ctl;
  assign bus.alu_a    = r_a;
  assign bus.alu_b    = r_b;
  assign bus.in_ready = (r_state == S_IDLE);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.result   = r_result;
  assign bus.hi       = r_hi;
  assign bus.dz       = r_dz;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.alucontrol == c_MUL) begin
            w_next = S_MUL;
          end else if (bus.alucontrol == c_DIV) begin
            w_next = S_DIV;
          end else begin
            w_next = S_ALU;
          end
        end
      end
      S_ALU:  w_next = S_DONE;
      S_MUL:  if (w_last) w_next = S_DONE;
      S_DIV:  if (w_b_zero || w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctl    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_ctl    <= bus.alucontrol;
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_cnt    <= c_CW'(WIDTH);
            r_acc_hi <= '0;
            r_acc_lo <= (bus.alucontrol == c_DIV) ? bus.a : bus.b;
          end
        end
        S_ALU: begin
          r_result <= bus.alu_y;
          r_hi     <= '0;
          r_dz     <= 1'b0;
        end
        S_MUL: begin
          r_acc_hi <= w_mul_hi;
          r_acc_lo <= w_mul_lo;
          r_cnt    <= r_cnt - c_CW'(1);
          if (w_last) begin
            r_result <= w_mul_lo;
            r_hi     <= w_mul_hi;
            r_dz     <= 1'b0;
          end
        end
        S_DIV: begin
          if (w_b_zero) begin
            r_result <= '1;
            r_hi     <= r_a;
            r_dz     <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_acc_hi <= w_div_rem;
            r_acc_lo <= w_div_quo;
            r_cnt    <= r_cnt - c_CW'(1);
            if (w_last) begin
              r_result <= w_div_quo;
              r_hi     <= w_div_rem;
              r_dz     <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer: directed cases, held
//                start, mid-operation reset and a randomized op sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  localparam int W = 16;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  alu_sequencer_if #(.WIDTH(W)) bus ();

  alu_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external combinational ALU
  function automatic logic [W-1:0] alu_model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    case (c)
      4'b0000: return x + y;
      4'b0001: return x - y;
      4'b0100: return x & y;
      4'b0101: return x | y;
      4'b0110: return x ^ y;
      4'b0111: return (x < y) ? W'(1) : W'(0);
      default: return x ^ ~y ^ W'(c);
    endcase
  endfunction

  assign bus.alu_y = alu_model(bus.alu_ctl, bus.alu_a, bus.alu_b);

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         dz;
    int           lat;
  } exp_t;

  // Reference arithmetic straight from the operation definitions
  function automatic exp_t ref_model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    logic [2*W-1:0] p;
    if (c == 4'b0010) begin
      p     = (2*W)'(x) * (2*W)'(y);
      e.res = p[W-1:0];
      e.hi  = p[2*W-1:W];
      e.dz  = 1'b0;
      e.lat = W + 1;
    end else if (c == 4'b0011) begin
      if (y == '0) begin
        e.res = '1;
        e.hi  = x;
        e.dz  = 1'b1;
        e.lat = 2;
      end else begin
        e.res = x / y;
        e.hi  = x % y;
        e.dz  = 1'b0;
        e.lat = W + 1;
      end
    end else begin
      e.res = alu_model(c, x, y);
      e.hi  = '0;
      e.dz  = 1'b0;
      e.lat = 2;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, wait for done, check results and latency
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    exp_t e;
    int   guard;
    int   cyc;
    e = ref_model(c, x, y);
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    bus.start      = 1'b1;
    bus.alucontrol = c;
    bus.a          = x;
    bus.b          = y;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.alucontrol = 4'($urandom);
    bus.a          = W'($urandom);
    bus.b          = W'($urandom);
    cyc = 1;
    chk({tag, "_alu_ctl"}, bus.alu_ctl, c);
    chk({tag, "_alu_a"}, bus.alu_a, x);
    chk({tag, "_alu_b"}, bus.alu_b, y);
    while (!bus.done && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_latency"}, cyc, e.lat);
    chk({tag, "_result"}, bus.result, e.res);
    chk({tag, "_hi"}, bus.hi, e.hi);
    chk({tag, "_dz"}, bus.dz, e.dz);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, bus.done, 0);
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    int done_cnt;
    exp_t e;
    logic [3:0] rc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    n_assert       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.alucontrol = 4'h0;
    bus.a          = '0;
    bus.b          = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_dz", bus.dz, 0);
    chk("rst_alu_ctl", bus.alu_ctl, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);

    // Directed cases
    run_op(4'b0000, 16'd3, 16'd4, "add");
    chk("add_value", bus.result, 16'h0007);
    run_op(4'b0010, 16'd300, 16'd500, "mul1");
    chk("mul1_hi_value", bus.hi, 16'h0002);
    chk("mul1_lo_value", bus.result, 16'h49F0);
    run_op(4'b0010, 16'hFFFF, 16'hFFFF, "mul_max");
    chk("mul_max_hi_value", bus.hi, 16'hFFFE);
    chk("mul_max_lo_value", bus.result, 16'h0001);
    run_op(4'b0011, 16'd1000, 16'd7, "div1");
    chk("div1_q_value", bus.result, 16'h008E);
    chk("div1_r_value", bus.hi, 16'h0006);
    run_op(4'b0011, 16'd5, 16'd0, "div0");
    chk("div0_q_value", bus.result, 16'hFFFF);
    chk("div0_r_value", bus.hi, 16'h0005);
    chk("div0_dz_value", bus.dz, 1);
    run_op(4'b0011, 16'hFFFF, 16'h0001, "div_by1");
    run_op(4'b0011, 16'h0003, 16'hFFFF, "div_small");
    run_op(4'b1010, 16'h1234, 16'h00FF, "jr");
    run_op(4'b1111, 16'hA5A5, 16'h5A5A, "op_f");

    // start held high through a MUL: second accept only after the IDLE cycle
    @(negedge clk);
    bus.start      = 1'b1;
    bus.alucontrol = 4'b0010;
    bus.a          = 16'd1234;
    bus.b          = 16'd4321;
    @(posedge clk);
    #1;
    cyc      = 1;
    busy_cnt = 0;
    while (!bus.done && cyc < 60) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (bus.busy) busy_cnt++;
    chk("hold_done_latency", cyc, 17);
    chk("hold_busy_cycles", busy_cnt, 17);
    e = ref_model(4'b0010, 16'd1234, 16'd4321);
    chk("hold_result", bus.result, e.res);
    chk("hold_hi", bus.hi, e.hi);
    @(posedge clk);
    #1;
    chk("hold_idle_in_ready", bus.in_ready, 1);
    chk("hold_idle_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    chk("hold_second_accept", bus.busy, 1);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("hold_second_latency", cyc, 17);
    chk("hold_second_result", bus.result, e.res);

    // Reset at cycle 8 of a MUL aborts without a done pulse
    @(negedge clk);
    bus.start      = 1'b1;
    bus.alucontrol = 4'b0010;
    bus.a          = 16'd77;
    bus.b          = 16'd99;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    reset     = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_alu_a", bus.alu_a, 0);
    done_cnt = 0;
    repeat (20) begin
      if (bus.done) done_cnt++;
      @(posedge clk);
      #1;
    end
    chk("abort_no_done", done_cnt, 0);
    run_op(4'b0000, 16'd10, 16'd20, "post_abort_add");

    // Randomized sweep over all op codes
    for (int i = 0; i < 1000; i++) begin
      rc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rc = 4'($urandom_range(2, 3));
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) ra = '1;
      run_op(rc, ra, rb, "rnd");
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
